button_event_gen: RTL and testbench

//  Consumes the debounced button level and turns it into one-cycle event pulses:

---
 rtl/button_event_gen.sv | 136 +++++++++++++
 tb/tb_button_event_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// Converts a debounced button level into one-cycle press, release, long-press and
// auto-repeat pulses. It also produces a held level and a wrapping press counter.
module button_event_gen #(
  parameter int LONG_LIMIT    = 12500000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int CNT_W         = 25
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch,
  output logic       o_Press,
  output logic       o_Release,
  output logic       o_Long,
  output logic       o_Repeat,
  output logic       o_Held,
  output logic [7:0] o_PressCount
);

  typedef enum logic [1:0] {
    WAIT_REL,
    IDLE,
    PRESSED,
    LONG
  } state_t;

  // The *_LAST constants fire on the edge where the count reaches its limit.
  // The *_MAX constants are the saturation values the counters park at.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_LIMIT - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_LIMIT);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] REP_MAX   = CNT_W'(REPEAT_PERIOD);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_next;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_cnt_next;
  logic             press_next;
  logic             release_next;
  logic             long_next;
  logic             repeat_next;
  logic             held_next;
  logic [7:0]       press_count_next;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state        <= WAIT_REL;
      hold_cnt     <= '0;
      rep_cnt      <= '0;
      o_Press      <= 1'b0;
      o_Release    <= 1'b0;
      o_Long       <= 1'b0;
      o_Repeat     <= 1'b0;
      o_Held       <= 1'b0;
      o_PressCount <= 8'd0;
    end else begin
      state        <= state_next;
      hold_cnt     <= hold_cnt_next;
      rep_cnt      <= rep_cnt_next;
      o_Press      <= press_next;
      o_Release    <= release_next;
      o_Long       <= long_next;
      o_Repeat     <= repeat_next;
      o_Held       <= held_next;
      o_PressCount <= press_count_next;
    end
  end

  // Release is tested before any threshold, so it wins a tie with long or repeat.
  always_comb begin
    state_next       = state;
    hold_cnt_next    = hold_cnt;
    rep_cnt_next     = rep_cnt;
    press_next       = 1'b0;
    release_next     = 1'b0;
    long_next        = 1'b0;
    repeat_next      = 1'b0;
    press_count_next = o_PressCount;

    case (state)
      WAIT_REL: begin
        if (!i_Switch) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        if (i_Switch) begin
          state_next       = PRESSED;
          press_next       = 1'b1;
          press_count_next = o_PressCount + 8'd1;
          hold_cnt_next    = '0;
        end
      end

      PRESSED: begin
        if (!i_Switch) begin
          state_next   = IDLE;
          release_next = 1'b1;
        end else if (hold_cnt == LONG_LAST) begin
          state_next    = LONG;
          long_next     = 1'b1;
          hold_cnt_next = LONG_MAX;
          rep_cnt_next  = '0;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end

      LONG: begin
        if (!i_Switch) begin
          state_next   = IDLE;
          release_next = 1'b1;
        end else if (rep_cnt == REP_LAST) begin
          if (REPEAT_EN) begin
            repeat_next  = 1'b1;
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = REP_MAX;
          end
        end else if (rep_cnt != REP_MAX) begin
          rep_cnt_next = rep_cnt + 1'b1;
        end
      end

      default: begin
        state_next = WAIT_REL;
      end
    endcase

    held_next = (state_next == PRESSED) || (state_next == LONG);
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Randomized scoreboard bench for button_event_gen. A time-since-press model predicts
// events and levels, and a negedge monitor compares them against the DUT.
module tb_button_event_gen;

  localparam int LL = 10;
  localparam int RP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw;
  logic       press, rel, lng, rpt, held;
  logic [7:0] pcnt;
  logic       press2, rel2, lng2, rpt2, held2;
  logic [7:0] pcnt2;

  typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2, EV_REPEAT = 3} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    int         edge_n;
    logic [7:0] count;
  } ev_t;
  typedef struct {
    int         edge_n;
    logic       held;
    logic [7:0] count;
  } lvl_t;

  ev_t  ev_q[$];
  lvl_t lvl_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit armed;
  bit pressed;
  int since;
  int model_count;
  int exp_press_total = 0;
  int exp_release_total = 0;
  int exp_long_total = 0;
  int press2_seen = 0;
  int rel2_seen = 0;
  int long2_seen = 0;
  int rpt2_seen = 0;

  button_event_gen #(.LONG_LIMIT(LL), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b1), .CNT_W(8)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Switch(sw),
    .o_Press(press), .o_Release(rel), .o_Long(lng), .o_Repeat(rpt),
    .o_Held(held), .o_PressCount(pcnt)
  );

  button_event_gen #(.LONG_LIMIT(LL), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b0), .CNT_W(8)) dut_norep (
    .i_Clk(clk), .i_Rst(rst), .i_Switch(sw),
    .o_Press(press2), .o_Release(rel2), .o_Long(lng2), .o_Repeat(rpt2),
    .o_Held(held2), .o_PressCount(pcnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d, required %0d (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushEvent(input ev_kind_t kind, input int e);
    ev_t ev;
    ev.kind   = kind;
    ev.edge_n = e;
    ev.count  = 8'(model_count);
    ev_q.push_back(ev);
  endtask

  // Reference model: reasons about the number of edges since the press edge.
  task automatic modelStep(input bit s, input int e);
    lvl_t lv;
    if (!armed) begin
      if (!s) armed = 1'b1;
    end else if (!pressed) begin
      if (s) begin
        pressed     = 1'b1;
        since       = 0;
        model_count = (model_count + 1) % 256;
        exp_press_total++;
        pushEvent(EV_PRESS, e);
      end
    end else if (!s) begin
      pressed = 1'b0;
      exp_release_total++;
      pushEvent(EV_RELEASE, e);
    end else begin
      since++;
      if (since == LL) begin
        exp_long_total++;
        pushEvent(EV_LONG, e);
      end else if (since > LL && ((since - LL) % RP) == 0) begin
        pushEvent(EV_REPEAT, e);
      end
    end
    lv.edge_n = e;
    lv.held   = pressed;
    lv.count  = 8'(model_count);
    lvl_q.push_back(lv);
  endtask

  task automatic applyStimulus(input bit s, input int n);
    repeat (n) begin
      @(negedge clk);
      modelStep(s, cyc + 1);
      sw = s;
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("reset_press", int'(press), 0);
    checkOutput("reset_release", int'(rel), 0);
    checkOutput("reset_long", int'(lng), 0);
    checkOutput("reset_repeat", int'(rpt), 0);
    checkOutput("reset_held", int'(held), 0);
    checkOutput("reset_count", int'(pcnt), 0);
    checkOutput("reset_held_norep", int'(held2), 0);
    checkOutput("reset_count_norep", int'(pcnt2), 0);
  endtask

  // Reset is asserted after the monitor has sampled this negedge.
  // That ordering makes the async clear itself observable.
  task automatic applyReset(input int n);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs();
    armed       = 1'b0;
    pressed     = 1'b0;
    model_count = 0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    lvl_t lv;
    ev_t  ev;
    int   hot;
    int   got_kind;
    while (lvl_q.size() > 0 && lvl_q[0].edge_n < cyc) begin
      lv = lvl_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL level_stale: actual unchecked, required check at edge %0d", lv.edge_n);
    end
    if (lvl_q.size() > 0 && lvl_q[0].edge_n == cyc) begin
      lv = lvl_q.pop_front();
      checkOutput("held", int'(held), int'(lv.held));
      checkOutput("press_count", int'(pcnt), int'(lv.count));
      checkOutput("held_norep", int'(held2), int'(lv.held));
      checkOutput("press_count_norep", int'(pcnt2), int'(lv.count));
    end
    while (ev_q.size() > 0 && ev_q[0].edge_n < cyc) begin
      ev = ev_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_event: actual none, required kind %0d at edge %0d",
               int'(ev.kind), ev.edge_n);
    end
    hot = int'(press) + int'(rel) + int'(lng) + int'(rpt);
    if (hot > 1) begin
      checks++;
      errors++;
      $display("[TB] FAIL one_hot: actual %0d pulses, required at most 1 (edge %0d)", hot, cyc);
    end
    if (hot != 0) begin
      got_kind = press ? 0 : (rel ? 1 : (lng ? 2 : 3));
      if (ev_q.size() == 0 || ev_q[0].edge_n != cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: actual kind %0d at edge %0d, required none",
                 got_kind, cyc);
      end else begin
        ev = ev_q.pop_front();
        checkOutput("event_kind", got_kind, int'(ev.kind));
        checkOutput("event_count", int'(pcnt), int'(ev.count));
      end
    end
    press2_seen += int'(press2);
    rel2_seen   += int'(rel2);
    long2_seen  += int'(lng2);
    rpt2_seen   += int'(rpt2);
  end

  initial begin
    rst         = 1'b1;
    sw          = 1'b0;
    armed       = 1'b0;
    pressed     = 1'b0;
    since       = 0;
    model_count = 0;
    repeat (3) @(negedge clk);
    #2;
    checkResetOutputs();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 3);

    $display("[TB] short press");
    applyStimulus(1, 5);
    applyStimulus(0, 4);

    $display("[TB] long hold with repeats");
    applyStimulus(1, 22);
    applyStimulus(0, 4);

    $display("[TB] release on long threshold edge");
    applyStimulus(1, LL);
    applyStimulus(0, 4);

    $display("[TB] release on repeat threshold edge");
    applyStimulus(1, LL + RP);
    applyStimulus(0, 4);

    $display("[TB] held through reset");
    applyStimulus(1, 3);
    applyReset(2);
    applyStimulus(1, 6);
    applyStimulus(0, 2);
    applyStimulus(1, 3);
    applyStimulus(0, 3);

    $display("[TB] reset mid-hold in LONG");
    applyStimulus(1, LL + 3);
    applyReset(2);
    applyStimulus(1, 3);
    applyStimulus(0, 2);
    applyStimulus(1, 2);
    applyStimulus(0, 3);

    $display("[TB] 30-cycle hold");
    applyStimulus(1, 30);
    applyStimulus(0, 3);

    $display("[TB] press counter wrap");
    applyReset(2);
    applyStimulus(0, 2);
    repeat (257) begin
      applyStimulus(1, 1);
      applyStimulus(0, 1);
    end
    applyStimulus(0, 2);
    checkOutput("wrap_count", int'(pcnt), 1);
    checkOutput("wrap_count_norep", int'(pcnt2), 1);

    $display("[TB] randomized bursts");
    repeat (40) begin
      applyStimulus(1, int'($urandom_range(1, 30)));
      if ($urandom_range(0, 7) == 0) applyReset(int'($urandom_range(1, 3)));
      applyStimulus(0, int'($urandom_range(1, 4)));
    end
    applyStimulus(0, 4);

    checkOutput("events_drained", ev_q.size(), 0);
    checkOutput("norep_repeats", rpt2_seen, 0);
    checkOutput("norep_longs", long2_seen, exp_long_total);
    checkOutput("norep_presses", press2_seen, exp_press_total);
    checkOutput("norep_releases", rel2_seen, exp_release_total);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
